// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit holding the architectural HI/LO registers.
// Latency: busy for WIDTH cycles after the accepting edge; done and new hi/lo follow in the next cycle.
// Backpressure: none; start is ignored while busy, and the hazard unit is expected not to issue it.
//
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   start, alu_op   issue request; alu_op 3 = MULTU, 4 = DIVU, anything else ignored
//   op_a, op_b      rs / rt operands
//   flush           abort the in-flight op; hi/lo keep their old values
//   busy, done      op in progress / one-cycle completion pulse
//   hi, lo          architectural HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  // r_q/q_q form one 2*WIDTH working register:
  //   MULTU: {partial product high, multiplier shifting out / product low}
  //   DIVU : {partial remainder, dividend shifting out / quotient shifting in}
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] r_nxt, q_nxt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  // flush beats a coincident start so a squashed instruction never issues.
  assign accept = (state_q == IDLE) && start && !flush &&
                  ((alu_op == 4'd3) || (alu_op == 4'd4));
  assign last   = (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (flush || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // One iteration of either algorithm.
  assign mul_sum  = {1'b0, r_q} + (q_q[0] ? {1'b0, d_q} : '0);
  assign div_sh   = {r_q, q_q[WIDTH-1]};
  // The compare needs the full WIDTH+1 bits so a remainder with its MSB set
  // still subtracts; with a zero divisor every step subtracts, giving
  // quotient all ones and remainder equal to the dividend.
  assign div_ge   = (div_sh >= {1'b0, d_q});
  // The difference is below the divisor whenever it is used, so WIDTH bits suffice.
  assign div_diff = div_sh[WIDTH-1:0] - d_q;

  always_comb begin
    r_nxt = r_q;
    q_nxt = q_q;
    if (is_div_q) begin
      r_nxt = div_ge ? div_diff : div_sh[WIDTH-1:0];
      q_nxt = {q_q[WIDTH-2:0], div_ge};
    end else begin
      r_nxt = mul_sum[WIDTH:1];
      q_nxt = {mul_sum[0], q_q[WIDTH-1:1]};
    end
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cnt_q    <= '0;
        is_div_q <= (alu_op == 4'd4);
        r_q      <= '0;
        q_q      <= (alu_op == 4'd4) ? op_a : op_b;
        d_q      <= (alu_op == 4'd4) ? op_b : op_a;
      end else if ((state_q == RUN) && !flush) begin
        r_q   <= r_nxt;
        q_q   <= q_nxt;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          hi_q   <= r_nxt;
          lo_q   <= q_nxt;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .alu_op (alu_op),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues the op, counts busy cycles and checks the done cycle.
  // If pulse_at > 0 a MULTU start is pulsed at that busy cycle and must be ignored.
  // Returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int pulse_at);
    int n;
    logic done_in_busy;
    start = 1'b1; alu_op = op; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; alu_op = 4'd0;
    n = 0;
    done_in_busy = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (done !== 1'b0) done_in_busy = 1'b1;
      if (n == pulse_at) begin
        start = 1'b1; alu_op = 4'd3; op_a = 32'd1000; op_b = 32'd1000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy cycles"}, 64'(n), 64'd32);
    chk({tag, " done while busy"}, {63'd0, done_in_busy}, 64'd0);
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; alu_op = 4'd3;
    op_a = 32'd7; op_b = 32'd9; flush = 1'b0;

    // 1. Reset with start held high
    repeat (2) @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi",   {32'd0, hi}, 64'd0);
    chk("reset lo",   {32'd0, lo}, 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 2. MULTU full-range
    run_op("mul ffff", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    @(negedge clk);
    chk("done one cycle", {63'd0, done}, 64'd0);

    // 3. DIVU and divide by zero, plus a few edge vectors
    run_op("div 100/7", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("div 5/0",   4'd4, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
    run_op("div max/1", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("div 3/7",   4'd4, 32'd3, 32'd7, 32'd3, 32'd0, 0);
    run_op("mul msb*2", 4'd3, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 0);

    // 4. Back-to-back, second start issued in the done cycle, stray start mid-busy
    run_op("b2b mul", 4'd3, 32'd3, 32'd4, 32'd0, 32'd12, 0);
    run_op("b2b div", 4'd4, 32'd9, 32'd2, 32'd1, 32'd4, 5);
    @(negedge clk);
    chk("stray start ignored", {63'd0, busy}, 64'd0);

    // 5. Flush at busy cycle 10; preload hi/lo = 0xA/0xB via 0xBA/0x10
    run_op("preload", 4'd4, 32'hBA, 32'h10, 32'hA, 32'hB, 0);
    start = 1'b1; alu_op = 4'd3; op_a = 32'd6; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush busy@10", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {63'd0, busy}, 64'd0);
    chk("flush done", {63'd0, done}, 64'd0);
    repeat (30) @(negedge clk);
    chk("flush late done", {63'd0, done}, 64'd0);
    chk("flush hi", {32'd0, hi}, 64'hA);
    chk("flush lo", {32'd0, lo}, 64'hB);

    // 6. Reset at busy cycle 20, then an illegal op and flush+start in IDLE
    start = 1'b1; alu_op = 4'd3; op_a = 32'd6; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("rst busy@20", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst done", {63'd0, done}, 64'd0);
    chk("midrst hi",   {32'd0, hi}, 64'd0);
    chk("midrst lo",   {32'd0, lo}, 64'd0);
    start = 1'b1; alu_op = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk("op5 ignored", {63'd0, busy}, 64'd0);
    start = 1'b1; alu_op = 4'd3; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush beats start", {63'd0, busy}, 64'd0);
    repeat (34) @(negedge clk);
    chk("no stray done", {63'd0, done}, 64'd0);
    chk("idle lo", {32'd0, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
